// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data-memory responder: request/response records,
// FSM state encoding and the wait-counter width.
package dmem_pkg;

    localparam int DMEM_LAT_W = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word RAM, byte write enables, registered read; 1-cycle read latency.
// No backpressure: the read register holds its value until the next enabled load.
module dmem_sram_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     wstrb,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset so committed stores survive arst_n.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store responder: one outstanding request, response LATENCY+1 cycles
// after accept; req_ready low until the held response is taken by rsp_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 0
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int                    AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0]           DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [DMEM_LAT_W-1:0] LAT_LOAD  = (LATENCY > 0) ? DMEM_LAT_W'(LATENCY - 1) : '0;

    dmem_req_t             req;
    dmem_rsp_t             rsp;
    dmem_state_t           state, state_nxt;
    logic [DMEM_LAT_W-1:0] cnt, cnt_nxt;
    logic                  load_q, load_nxt;
    logic                  err_q, err_nxt;
    logic                  accept, in_range;
    logic [31:0]           ram_rdata;
    logic                  unused_addr_bits;

    assign req = '{addr: req_addr, we: req_we, wdata: req_wdata, wstrb: req_wstrb};

    assign in_range         = req.addr[31:2] < DEPTH_LIM;
    assign accept           = req_valid && req_ready;
    assign unused_addr_bits = ^req.addr[1:0];

    // The RAM's read register doubles as the response data register; load_q gates it out.
    dmem_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
        .clk   (clk),
        .en    (accept && in_range),
        .we    (req.we),
        .addr  (req.addr[AW+1:2]),
        .wdata (req.wdata),
        .wstrb (req.wstrb),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            load_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            load_q <= load_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_nxt  = load_q;
        err_nxt   = err_q;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_nxt = in_range && !req.we;
                    err_nxt  = !in_range;
                    if (LATENCY > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = LAT_LOAD;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                    load_nxt  = 1'b0;
                    err_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp.rdata = (state == RESP && load_q) ? ram_rdata : '0;
    assign rsp.err   = (state == RESP) && err_q;

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the core's MEM stage. It sits at the far end of the load/store request issued by the LSU, accepts one word-addressed request per transaction under a valid/ready handshake, and commits byte-strobed writes into an internal synchronous RAM. It returns read data or an error flag after a configurable number of wait cycles, and holds the response until the MEM stage takes it.

## Interface

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Power of two, ≥ 2.
- LATENCY, 0: extra wait cycles between acceptance and response. Range 0–15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
  - Bits [1:0] are ignored; byte lanes are selected by req_wstrb.
  - Word index is bits [log2(DEPTH_WORDS)+1:2].
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data, lane-aligned by the LSU.
- req_wstrb  in  4  per-byte write enables; ignored when req_we = 0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  MEM stage takes the response.
- rsp_rdata  out  32  full word read; 0 for stores and errors.
- rsp_err  out  1  address out of range.

## Operation

- Accept event: rising edge with req_valid && req_ready.
- Range check: the request is out of range when req_addr[31:2] ≥ DEPTH_WORDS.
- At the accept edge:
  - In-range store: write the bytes selected by wstrb. Unselected bytes are unchanged. wstrb = 0000 is a legal no-op store.
  - In-range load: read the full word into the rdata register.
  - Out-of-range request: no RAM write; rdata register = 0; err register = 1.
  - The request fields are not needed after acceptance; nothing else is held.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On accept: go to WAIT with counter = LATENCY−1 if LATENCY > 0, else go to RESP.
  - WAIT: req_ready = 0. Counter decrements each cycle. When it reaches 0, go to RESP.
  - RESP: rsp_valid = 1 and req_ready = 0. rsp_rdata and rsp_err are stable until handshake. On rsp_ready, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err.
- Only one transaction is outstanding at any time. Requests presented while not in IDLE are not accepted and stay pending at the source.
- Counter width is 4 bits. It never wraps, because it is loaded only in IDLE and stops at 0.
- RAM contents are not reset. A store committed before reset asserts survives it.

## Timing

- Reset values (arst_n low, immediate, asynchronous):
  - state = IDLE, counter = 0.
  - req_ready = 1 (combinational from state).
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Latency: rsp_valid rises LATENCY+1 cycles after the accept edge. For LATENCY = 0, it is high in the cycle after acceptance.
- Throughput: at most one transaction per LATENCY+2 cycles. The next request is accepted no earlier than the cycle after the response handshake; there is no same-cycle turnaround.
- rsp_ready held high before rsp_valid: the handshake completes in the first RESP cycle.
- rsp_ready low: RESP is held indefinitely with outputs frozen.
- Reset mid-transaction: the pending response is dropped and no response is issued. An already-committed store remains in RAM.
- A load following a store to the same word returns the new data, because the store is committed at its accept edge.

## Structure

- Package dmem_pkg:
  - dmem_req_t: addr, we, wdata, wstrb.
  - dmem_rsp_t: rdata, err.
  - dmem_state_t: IDLE, WAIT, RESP.
  - DMEM_LAT_W = 4.
- Sub-module dmem_sram_array:
  - Synchronous single-port RAM with 4 byte-write enables and a registered read port.
  - Parameter DEPTH_WORDS.
- The responder holds the FSM, the counter, the range check and the response registers.

## Test plan

- Reset/idle, LATENCY = 0: release reset → req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Store then load, LATENCY = 0:
  - Store 0x00000010, wdata 0xDEADBEEF, wstrb 1111.
  - Load 0x00000010 → rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid one cycle after each accept.
- Byte strobes:
  - Prior word 0xDEADBEEF.
  - Store 0x00000012, wdata 0x00AA0000, wstrb 0100.
  - Load 0x00000010 → 0xDEAABEEF.
- Latency and backpressure, LATENCY = 3:
  - rsp_valid rises 4 cycles after accept.
  - Hold rsp_ready = 0 for 5 cycles → data stable, req_ready = 0 throughout.
  - Raise rsp_ready → IDLE the next cycle.
- Out of range, DEPTH_WORDS = 1024:
  - Store 0x00001000 → rsp_err = 1, rsp_rdata = 0.
  - Load word 0 afterwards → unchanged.
- Reset during WAIT, LATENCY = 5:
  - Assert arst_n low 2 cycles after a store accept → rsp_valid = 0 immediately and stays 0 after release.
  - A later load of the same address returns the stored data.
